ms6205_refresh_sequencer: RTL and testbench

//  Drives the MS6205 character display write port (address/data/write_addr/write_data/ready).

---
 rtl/ms6205_refresh_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ms6205_refresh_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms6205_refresh_sequencer.sv
// MS6205 display refresh sequencer.
// Scans every display cell, fetching each character from the view-selected source, and
// writes it through the address/data strobe handshake. A priority single-cell update port
// is slotted in between cell writes and never splits one.
module ms6205_refresh_sequencer #(
  parameter int unsigned COLUMNS       = 16,
  parameter int unsigned ROWS          = 10,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned RDY_TIMEOUT   = 255
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] view,
  input  logic       refresh,
  input  logic       auto_refresh,
  output logic       rd_req,
  output logic [9:0] rd_addr,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  input  logic       upd_req,
  input  logic [7:0] upd_addr,
  input  logic [7:0] upd_char,
  output logic       upd_ack,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       write_addr,
  output logic       write_data,
  input  logic       ready,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout
);

  localparam int unsigned Cells    = COLUMNS * ROWS;
  localparam logic [7:0]  LastCell = 8'(Cells - 1);
  localparam logic [8:0]  CellsW   = 9'(Cells);

  localparam int unsigned StbW             = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [StbW-1:0] StbLast      = StbW'(STROBE_CYCLES - 1);
  localparam int unsigned RdyW             = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
  localparam logic [RdyW-1:0] RdyLast      = RdyW'(RDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StFetch,
    StWaitRd,
    StAddr,
    StData,
    StWaitRdy,
    StNext
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cell_q, cell_d;
  logic [1:0]      view_q, view_d;
  logic            pending_q, pending_d;
  logic            upd_q, upd_d;        // current cell write belongs to the update port
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      char_q, char_d;
  logic [StbW-1:0] stb_q, stb_d;
  logic [RdyW-1:0] rdy_q, rdy_d;
  logic            timeout_q, timeout_d;

  // State and datapath registers; reset drops strobes at once since they decode state_q.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      cell_q    <= 8'd0;
      view_q    <= 2'd0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      addr_q    <= 8'd0;
      char_q    <= 8'd0;
      stb_q     <= '0;
      rdy_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      view_q    <= view_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      addr_q    <= addr_d;
      char_q    <= char_d;
      stb_q     <= stb_d;
      rdy_q     <= rdy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic and per-state pulse outputs.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    view_d     = view_q;
    pending_d  = pending_q;
    upd_d      = upd_q;
    addr_d     = addr_q;
    char_d     = char_q;
    stb_d      = stb_q;
    rdy_d      = rdy_q;
    timeout_d  = timeout_q;
    rd_req     = 1'b0;
    write_addr = 1'b0;
    write_data = 1'b0;
    upd_ack    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (refresh) begin
          pending_d = 1'b1;
          view_d    = view;
          cell_d    = 8'd0;
          timeout_d = 1'b0;
          state_d   = StArb;
        end else if (upd_req) begin
          state_d = StArb;
        end
      end

      StArb: begin
        if (upd_req) begin
          upd_d = 1'b1;
          stb_d = '0;
          if ({1'b0, upd_addr} < CellsW) begin
            addr_d  = upd_addr;
            char_d  = upd_char & 8'h7F;
            state_d = StAddr;
          end else begin
            // Out-of-range cell: no display write, but the requester still gets its ack.
            state_d = StNext;
          end
        end else if (pending_q) begin
          upd_d   = 1'b0;
          state_d = StFetch;
        end else begin
          upd_d   = 1'b0;
          state_d = StIdle;
        end
      end

      StFetch: begin
        rd_req  = 1'b1;
        addr_d  = cell_q;
        state_d = StWaitRd;
      end

      StWaitRd: begin
        if (rd_valid) begin
          char_d  = rd_data & 8'h7F;
          stb_d   = '0;
          state_d = StAddr;
        end
      end

      StAddr: begin
        write_addr = 1'b1;
        if (stb_q == StbLast) begin
          stb_d   = '0;
          state_d = StData;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end

      StData: begin
        write_data = 1'b1;
        if (stb_q == StbLast) begin
          stb_d   = '0;
          rdy_d   = '0;
          state_d = StWaitRdy;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end

      StWaitRdy: begin
        if (ready) begin
          state_d = StNext;
        end else if (rdy_q == RdyLast) begin
          timeout_d = 1'b1;
          state_d   = StNext;
        end else begin
          rdy_d = rdy_q + 1'b1;
        end
      end

      StNext: begin
        state_d = StArb;
        if (upd_q) begin
          upd_ack = 1'b1;
        end else if (cell_q == LastCell) begin
          cell_d     = 8'd0;
          frame_done = 1'b1;
          pending_d  = auto_refresh;
          view_d     = view;
        end else if (view != view_q) begin
          // View changed mid-frame: abandon this frame and restart from cell 0.
          cell_d = 8'd0;
          view_d = view;
        end else begin
          cell_d = cell_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Level outputs straight from registered state.
  always_comb begin
    busy    = (state_q != StIdle);
    rd_addr = {view_q, cell_q};
    address = addr_q;
    data    = char_q;
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_ms6205_refresh_sequencer.sv
// Directed bench for ms6205_refresh_sequencer: a character source model, a write monitor and
// a scoreboard of expected (address, char) pairs pushed when the source is driven.
module tb_ms6205_refresh_sequencer;

  localparam int unsigned SC    = 3;
  localparam int unsigned TO    = 255;
  localparam int unsigned CELLS = 160;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] view;
  logic       refresh, auto_refresh;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       upd_req;
  logic [7:0] upd_addr, upd_char;
  logic       upd_ack;
  logic [7:0] address, data;
  logic       write_addr, write_data;
  logic       ready;
  logic       busy, frame_done, timeout;

  ms6205_refresh_sequencer #(
    .COLUMNS      (16),
    .ROWS         (10),
    .STROBE_CYCLES(SC),
    .RDY_TIMEOUT  (TO)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .view        (view),
    .refresh     (refresh),
    .auto_refresh(auto_refresh),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .upd_req     (upd_req),
    .upd_addr    (upd_addr),
    .upd_char    (upd_char),
    .upd_ack     (upd_ack),
    .address     (address),
    .data        (data),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .ready       (ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout     (timeout)
  );

  initial forever #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] sb[$];

  // Source model state
  logic [1:0] exp_view = 2'd0;
  logic [7:0] exp_cell = 8'd0;
  int         rd_lat   = 1;
  int         rd_wait  = 0;
  logic       rd_pend  = 1'b0;
  logic [9:0] rd_hold  = 10'd0;
  logic       rd_now   = 1'b0;
  logic [7:0] seen_cell = 8'd0;

  // Write monitor state
  logic       in_write = 1'b0;
  logic       hold     = 1'b0;
  int         wa_cnt = 0, wd_cnt = 0;
  logic [7:0] w_addr = 8'd0, w_data = 8'd0;
  logic [7:0] last_w_addr = 8'd0;
  int         writes = 0, frames = 0, acks = 0, stab_bad = 0;
  int         last_wd_cyc = 0, wd5_cyc = 0, to_rise_cyc = 0;
  logic       to_prev = 1'b0;

  function automatic logic [7:0] src_char(input logic [9:0] a);
    logic [7:0] m;
    m = a[7:0] * 8'd37;
    return m ^ {a[9:8], 6'h2B};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample at the falling edge, run source model and write monitor.
  task automatic step();
    logic [15:0] e;
    @(negedge Clk);
    cyc++;
    rd_now = 1'b0;
    if (rd_valid) rd_valid = 1'b0;
    if (rd_pend) begin
      rd_wait--;
      if (rd_wait == 0) begin
        rd_valid = 1'b1;
        rd_data  = src_char(rd_hold);
        rd_pend  = 1'b0;
      end
    end
    if (rd_req) begin
      rd_now    = 1'b1;
      seen_cell = rd_addr[7:0];
      chk("rd_addr", 32'(rd_addr), 32'({exp_view, exp_cell}));
      sb.push_back({exp_cell, src_char({exp_view, exp_cell}) & 8'h7F});
      exp_cell = (exp_cell == 8'(CELLS - 1)) ? 8'd0 : exp_cell + 8'd1;
      rd_hold  = rd_addr;
      rd_wait  = rd_lat;
      rd_pend  = 1'b1;
    end

    if (write_addr && !in_write) begin
      in_write = 1'b1;
      hold     = 1'b1;
      wa_cnt   = 0;
      wd_cnt   = 0;
      w_addr   = address;
      w_data   = data;
    end
    if (hold && (address !== w_addr || data !== w_data)) stab_bad++;
    if (write_addr) wa_cnt++;
    if (write_data) begin
      wd_cnt++;
      last_wd_cyc = cyc;
    end
    if (in_write && wd_cnt > 0 && !write_data) begin
      in_write = 1'b0;
      writes++;
      chk("wa_width", 32'(wa_cnt), SC);
      chk("wd_width", 32'(wd_cnt), SC);
      chk("sb_avail", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(w_addr), 32'(e[15:8]));
        chk("wr_data", 32'(w_data), 32'(e[7:0]));
      end
      last_w_addr = w_addr;
      if (w_addr == 8'd5) wd5_cyc = last_wd_cyc;
    end
    if (rd_req) hold = 1'b0;

    if (frame_done) begin
      frames++;
      chk("frame_last", 32'(last_w_addr), CELLS - 1);
    end
    if (upd_ack) begin
      acks++;
      upd_req = 1'b0;
    end
    if (timeout && !to_prev) to_rise_cyc = cyc;
    to_prev = timeout;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
  endtask

  task automatic wait_cell(input string tag, input logic [7:0] c);
    int n = 0;
    while (!(rd_now && seen_cell == c) && n < 2000) begin
      step();
      n++;
    end
    chk(tag, 32'(rd_now && seen_cell == c), 1);
  endtask

  initial begin
    int n, f0, w0, a0;
    Rst_n = 1'b0; view = 2'b00; refresh = 1'b0; auto_refresh = 1'b0;
    rd_data = 8'd0; rd_valid = 1'b0; upd_req = 1'b0; upd_addr = 8'd0; upd_char = 8'd0;
    ready = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({write_addr, write_data, rd_req}), 0);
    chk("rst_pulses", 32'({upd_ack, frame_done, timeout}), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_data", 32'(data), 0);
    Rst_n = 1'b1;
    step();

    // 1: full scan, view 00, latency 1, ready tied high
    pulse_refresh();
    wait_idle("t1_idle");
    chk("t1_frames", 32'(frames), 1);
    chk("t1_writes", 32'(writes), CELLS);
    chk("t1_timeout", 32'(timeout), 0);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: ready held low for 300 cycles during cell 5
    f0 = frames; w0 = writes;
    pulse_refresh();
    wait_cell("t2_reach5", 8'd5);
    ready = 1'b0;
    to_rise_cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 200) chk("t2_to_early", 32'(timeout), 0);
    end
    chk("t2_to_set", 32'(timeout), 1);
    chk("t2_to_delay", 32'(to_rise_cyc - wd5_cyc), TO + 1);
    chk("t2_cell6_written", 32'(writes - w0), 7);
    ready = 1'b1;
    wait_idle("t2_idle");
    chk("t2_to_sticky", 32'(timeout), 1);
    chk("t2_frames", 32'(frames - f0), 1);
    chk("t2_writes", 32'(writes - w0), CELLS);

    // 3: update request while cell 10 is in flight
    f0 = frames; w0 = writes; a0 = acks;
    pulse_refresh();
    chk("t3_to_clr", 32'(timeout), 0);
    wait_cell("t3_reach10", 8'd10);
    upd_addr = 8'h42; upd_char = 8'h41; upd_req = 1'b1;
    sb.push_back(16'h4241);
    n = 0;
    while (acks == a0 && n < 1000) begin
      step();
      n++;
    end
    chk("t3_ack", 32'(acks - a0), 1);
    chk("t3_upd_last", 32'(last_w_addr), 32'h42);
    chk("t3_writes_at_ack", 32'(writes - w0), 12);
    wait_idle("t3_idle");
    chk("t3_frames", 32'(frames - f0), 1);
    chk("t3_writes", 32'(writes - w0), CELLS + 1);

    // Out-of-range update: acked, nothing written, timeout untouched
    w0 = writes; a0 = acks;
    upd_addr = 8'd200; upd_char = 8'h33; upd_req = 1'b1;
    n = 0;
    while (acks == a0 && n < 100) begin
      step();
      n++;
    end
    chk("oor_ack", 32'(acks - a0), 1);
    wait_idle("oor_idle");
    chk("oor_no_write", 32'(writes - w0), 0);
    chk("oor_timeout", 32'(timeout), 0);

    // 4: view 00 -> 10 during cell 50, source latency 3
    rd_lat = 3;
    f0 = frames; w0 = writes;
    pulse_refresh();
    wait_cell("t4_reach50", 8'd50);
    view = 2'b10;
    exp_view = 2'b10;
    exp_cell = 8'd0;
    wait_idle("t4_idle");
    chk("t4_frames", 32'(frames - f0), 1);
    chk("t4_writes", 32'(writes - w0), 51 + CELLS);
    chk("t4_sb_empty", 32'(sb.size()), 0);
    rd_lat = 1;

    // 6: reset asserted during the data strobe of an update
    a0 = acks;
    upd_addr = 8'h07; upd_char = 8'hD5; upd_req = 1'b1;
    sb.push_back(16'h0755);
    n = 0;
    while (!write_data && n < 100) begin
      step();
      n++;
    end
    chk("t6_in_data", 32'(write_data), 1);
    Rst_n = 1'b0;
    #1;
    chk("t6_wd_drop", 32'(write_data), 0);
    chk("t6_wa_low", 32'(write_addr), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    upd_req = 1'b0;
    sb.delete();
    in_write = 1'b0; hold = 1'b0; rd_pend = 1'b0; rd_valid = 1'b0;
    repeat (2) step();
    Rst_n = 1'b1;
    repeat (3) step();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_address", 32'(address), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_no_ack", 32'(acks - a0), 0);

    chk("stable_addr_data", 32'(stab_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
